// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider / tick generator for slow peripherals in the clk domain.
// Optional macro CLK_DIV_PROG_SYNC_EN adds a sync_in pulse that phase-aligns all running channels.

module clk_div_prog_ch #(
    parameter int DIV_W    = 16,
    parameter int DEF_DIV  = 16,
    parameter int DEF_HIGH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] div_in,
    input  logic [DIV_W-1:0] high_in,
    input  logic             sync_pulse,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] high;
    } cfg_t;

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

    // Period of at least 2 and a high time strictly shorter than the period.
    function automatic cfg_t sanitize(input logic [DIV_W-1:0] d, input logic [DIV_W-1:0] h);
        cfg_t c;
        c.div  = (d < TWO) ? TWO : d;
        c.high = (h > c.div - ONE) ? c.div - ONE : h;
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    cfg_t             act_q, act_d;
    cfg_t             pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             running_q, running_d;

    cfg_t cfg_new;
    logic active;
    logic last;
    logic wrap;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        cfg_new = sanitize(div_in, high_in);
        active  = (state_q != IDLE);
        last    = (cnt_q == act_q.div - ONE);
        // sync_pulse behaves as an early wrap and overrides a coincident natural one.
        wrap    = active && (sync_pulse || last);

        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = STOP;
            STOP: begin
                if (en)        state_d = RUN;
                else if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!active || wrap) cnt_d = '0;
        else                 cnt_d = cnt_q + ONE;

        // Pending config only lands on a period boundary so no period is cut short or stretched.
        if (wrap && pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
        end

        // A load on the wrap cycle goes to pending for the following boundary.
        if (cfg_load) begin
            if (!active) begin
                act_d = cfg_new;
            end else begin
                pend_d       = cfg_new;
                pend_valid_d = 1'b1;
            end
        end

        clk_out_d = active && (cnt_q < act_q.high);
        tick_d    = active && (cnt_q == '0);
        running_d = active;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            act_q        <= sanitize(DIV_W'(DEF_DIV), DIV_W'(DEF_HIGH));
            pend_q       <= sanitize(DIV_W'(DEF_DIV), DIV_W'(DEF_HIGH));
            pend_valid_q <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            running_q    <= running_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign running = running_q;
endmodule

module clk_div_prog #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 16,
    parameter int DEF_DIV  = 16,
    parameter int DEF_HIGH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       cfg_load,
    input  logic [NUM_CH*DIV_W-1:0] div_in,
    input  logic [NUM_CH*DIV_W-1:0] high_in,
`ifdef CLK_DIV_PROG_SYNC_EN
    input  logic                    sync_in,
`endif
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       running
);
    logic [NUM_CH-1:0][DIV_W-1:0] div_vec;
    logic [NUM_CH-1:0][DIV_W-1:0] high_vec;
    logic                         sync_w;

    assign div_vec  = div_in;
    assign high_vec = high_in;

`ifdef CLK_DIV_PROG_SYNC_EN
    assign sync_w = sync_in;
`else
    assign sync_w = 1'b0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_prog_ch #(
            .DIV_W    (DIV_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en[c]),
            .cfg_load   (cfg_load[c]),
            .div_in     (div_vec[c]),
            .high_in    (high_vec[c]),
            .sync_pulse (sync_w),
            .clk_out    (clk_out[c]),
            .tick       (tick[c]),
            .running    (running[c])
        );
    end
endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: expected per-edge outputs are queued as stimulus is driven.
module tb_clk_div_prog;
    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;

    logic                    clk;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       cfg_load;
    logic [NUM_CH*DIV_W-1:0] div_in;
    logic [NUM_CH*DIV_W-1:0] high_in;
    logic                    sync_in;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       running;

    typedef struct {
        logic [NUM_CH-1:0] mask;
        logic [NUM_CH-1:0] co;
        logic [NUM_CH-1:0] tk;
        logic [NUM_CH-1:0] rn;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    clk_div_prog #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(16), .DEF_HIGH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_load (cfg_load),
        .div_in   (div_in),
        .high_in  (high_in),
`ifdef CLK_DIV_PROG_SYNC_EN
        .sync_in  (sync_in),
`endif
        .clk_out  (clk_out),
        .tick     (tick),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t zero_exp(input logic [NUM_CH-1:0] m);
        exp_t e;
        e.mask = m;
        e.co   = '0;
        e.tk   = '0;
        e.rn   = '0;
        return e;
    endfunction

    task automatic test_reset;
        exp_t e;
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (j == 2) rst = 1'b0;
            sb.push_back(zero_exp('1));
            step;
            e = sb.pop_front();
            n_chk++;
            if ({clk_out & e.mask, tick & e.mask, running & e.mask} !== {e.co, e.tk, e.rn}) begin
                n_fail++;
                $display("FAIL reset j=%0d got co=%b tk=%b rn=%b want co=%b tk=%b rn=%b",
                         j, clk_out, tick, running, e.co, e.tk, e.rn);
            end
        end
    endtask

    task automatic test_default;
        exp_t e;
        int   k;
        en[0] = 1'b1;
        for (int j = 0; j <= 33; j++) begin
            e = zero_exp(4'b0001);
            if (j > 0) begin
                k = (j - 1) % 16;
                e.co[0] = (k < 8);
                e.tk[0] = (k == 0);
                e.rn[0] = 1'b1;
            end
            sb.push_back(e);
            step;
            e = sb.pop_front();
            n_chk++;
            if ({clk_out & e.mask, tick & e.mask, running & e.mask} !== {e.co, e.tk, e.rn}) begin
                n_fail++;
                $display("FAIL default_ch0 j=%0d got co=%b tk=%b rn=%b want co=%b tk=%b rn=%b",
                         j, clk_out[0], tick[0], running[0], e.co[0], e.tk[0], e.rn[0]);
            end
        end
    endtask

    task automatic test_reprogram;
        exp_t e;
        int   k;
        int   hi;
        div_in[16 +: 16]  = 16'd5;
        high_in[16 +: 16] = 16'd2;
        cfg_load          = 4'b0010;
        step;
        cfg_load = '0;
        en[1]    = 1'b1;
        for (int j = 0; j <= 24; j++) begin
            if (j == 13) begin
                div_in[16 +: 16]  = 16'd3;
                high_in[16 +: 16] = 16'd1;
                cfg_load[1]       = 1'b1;
            end
            e = zero_exp(4'b0010);
            if (j > 0) begin
                if (j <= 15) begin k = (j - 1) % 5;  hi = 2; end
                else         begin k = (j - 16) % 3; hi = 1; end
                e.co[1] = (k < hi);
                e.tk[1] = (k == 0);
                e.rn[1] = 1'b1;
            end
            sb.push_back(e);
            step;
            cfg_load = '0;
            e = sb.pop_front();
            n_chk++;
            if ({clk_out & e.mask, tick & e.mask, running & e.mask} !== {e.co, e.tk, e.rn}) begin
                n_fail++;
                $display("FAIL reprogram_ch1 j=%0d got co=%b tk=%b rn=%b want co=%b tk=%b rn=%b",
                         j, clk_out[1], tick[1], running[1], e.co[1], e.tk[1], e.rn[1]);
            end
        end
    endtask

    task automatic test_boundary;
        exp_t e;
        int   k;
        // div=0/high=7 collapses to div=2/high=1
        div_in[48 +: 16]  = 16'd0;
        high_in[48 +: 16] = 16'd7;
        cfg_load          = 4'b1000;
        step;
        cfg_load = '0;
        en[3]    = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            e = zero_exp(4'b1000);
            if (j > 0) begin
                k = (j - 1) % 2;
                e.co[3] = (k < 1);
                e.tk[3] = (k == 0);
                e.rn[3] = 1'b1;
            end
            sb.push_back(e);
            step;
            e = sb.pop_front();
            n_chk++;
            if ({clk_out & e.mask, tick & e.mask, running & e.mask} !== {e.co, e.tk, e.rn}) begin
                n_fail++;
                $display("FAIL div0_ch3 j=%0d got co=%b tk=%b rn=%b want co=%b tk=%b rn=%b",
                         j, clk_out[3], tick[3], running[3], e.co[3], e.tk[3], e.rn[3]);
            end
        end
        en[3] = 1'b0;
        repeat (3) step;
        sb.push_back(zero_exp(4'b1000));
        step;
        e = sb.pop_front();
        n_chk++;
        if ({clk_out & e.mask, tick & e.mask, running & e.mask} !== {e.co, e.tk, e.rn}) begin
            n_fail++;
            $display("FAIL stop_ch3 got co=%b tk=%b rn=%b want all 0", clk_out[3], tick[3], running[3]);
        end
        div_in[48 +: 16]  = 16'd4;
        high_in[48 +: 16] = 16'd0;
        cfg_load          = 4'b1000;
        step;
        cfg_load = '0;
        en[3]    = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            e = zero_exp(4'b1000);
            if (j > 0) begin
                k = (j - 1) % 4;
                e.tk[3] = (k == 0);
                e.rn[3] = 1'b1;
            end
            sb.push_back(e);
            step;
            e = sb.pop_front();
            n_chk++;
            if ({clk_out & e.mask, tick & e.mask, running & e.mask} !== {e.co, e.tk, e.rn}) begin
                n_fail++;
                $display("FAIL high0_ch3 j=%0d got co=%b tk=%b rn=%b want co=%b tk=%b rn=%b",
                         j, clk_out[3], tick[3], running[3], e.co[3], e.tk[3], e.rn[3]);
            end
        end
    endtask

    task automatic test_stop_restart;
        exp_t e;
        int   k;
        div_in[32 +: 16]  = 16'd10;
        high_in[32 +: 16] = 16'd5;
        cfg_load          = 4'b0100;
        step;
        cfg_load = '0;
        for (int j = 0; j <= 50; j++) begin
            // drop at cnt=3 -> idle; restart; drop at cnt=3, reassert at cnt=7 while stopping
            en[2] = !((j >= 14 && j <= 24) || (j >= 29 && j <= 32));
            e = zero_exp(4'b0100);
            if (j >= 1 && j <= 20) begin
                k = (j - 1) % 10;
                e.co[2] = (k < 5);
                e.tk[2] = (k == 0);
                e.rn[2] = 1'b1;
            end else if (j >= 26) begin
                k = (j - 26) % 10;
                e.co[2] = (k < 5);
                e.tk[2] = (k == 0);
                e.rn[2] = 1'b1;
            end
            sb.push_back(e);
            step;
            e = sb.pop_front();
            n_chk++;
            if ({clk_out & e.mask, tick & e.mask, running & e.mask} !== {e.co, e.tk, e.rn}) begin
                n_fail++;
                $display("FAIL stop_ch2 j=%0d got co=%b tk=%b rn=%b want co=%b tk=%b rn=%b",
                         j, clk_out[2], tick[2], running[2], e.co[2], e.tk[2], e.rn[2]);
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   k;
        en       = '1;
        cfg_load = '0;
        rst      = 1'b1;
        for (int j = -2; j <= 20; j++) begin
            if (j == 0) rst = 1'b0;
            e = zero_exp('1);
            if (j > 0) begin
                k = (j - 1) % 16;
                e.co = (k < 8) ? '1 : '0;
                e.tk = (k == 0) ? '1 : '0;
                e.rn = '1;
            end
            sb.push_back(e);
            step;
            e = sb.pop_front();
            n_chk++;
            if ({clk_out & e.mask, tick & e.mask, running & e.mask} !== {e.co, e.tk, e.rn}) begin
                n_fail++;
                $display("FAIL reset_mid j=%0d got co=%b tk=%b rn=%b want co=%b tk=%b rn=%b",
                         j, clk_out, tick, running, e.co, e.tk, e.rn);
            end
        end
    endtask

`ifdef CLK_DIV_PROG_SYNC_EN
    task automatic test_sync;
        exp_t e;
        int   k0;
        int   k1;
        div_in[0 +: 16]   = 16'd6;
        high_in[0 +: 16]  = 16'd3;
        div_in[16 +: 16]  = 16'd4;
        high_in[16 +: 16] = 16'd2;
        cfg_load          = 4'b0011;
        step;
        cfg_load = '0;
        repeat (3) step;
        sync_in = 1'b1;
        step;
        sync_in = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            k0 = (j - 1) % 6;
            k1 = (j - 1) % 4;
            e = zero_exp(4'b0011);
            e.co = {2'b00, 1'(k1 < 2), 1'(k0 < 3)};
            e.tk = {2'b00, 1'(k1 == 0), 1'(k0 == 0)};
            e.rn = 4'b0011;
            sb.push_back(e);
            step;
            e = sb.pop_front();
            n_chk++;
            if ({clk_out & e.mask, tick & e.mask, running & e.mask} !== {e.co, e.tk, e.rn}) begin
                n_fail++;
                $display("FAIL sync j=%0d got co=%b tk=%b rn=%b want co=%b tk=%b rn=%b",
                         j, clk_out & e.mask, tick & e.mask, running & e.mask, e.co, e.tk, e.rn);
            end
        end
    endtask
`endif

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        en       = '0;
        cfg_load = '0;
        div_in   = '0;
        high_in  = '0;
        sync_in  = 1'b0;
        test_reset;
        test_default;
        test_reprogram;
        test_boundary;
        test_stop_restart;
        test_reset_mid;
`ifdef CLK_DIV_PROG_SYNC_EN
        test_sync;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
